// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: latches decode outputs, forwards
// from EX/MEM and MEM/WB, and flags load-use hazards for the stall controller.
module id_ex_operand_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              id_alu_src,
  input  logic [2:0]        id_alu_sel,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   alu_op_a,
  output logic [XLEN-1:0]   alu_op_b,
  output logic [2:0]        alu_sel,
  output logic [XLEN-1:0]   ex_store_data,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic              load_use_hazard
);

  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              branch_q, branch_d;
  logic              alu_src_q, alu_src_d;
  logic [2:0]        sel_q, sel_d;
  logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [XLEN-1:0]   pc_q, pc_d;

  logic wb_hit_rs1, wb_hit_rs2, mem_hit_rs1, mem_hit_rs2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  assign mem_hit_rs1 = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs1_addr_q);
  assign mem_hit_rs2 = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs2_addr_q);
  assign wb_hit_rs1  = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs1_addr_q);
  assign wb_hit_rs2  = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs2_addr_q);

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    branch_d    = branch_q;
    alu_src_d   = alu_src_q;
    sel_d       = sel_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      branch_d    = 1'b0;
      alu_src_d   = 1'b0;
      sel_d       = '0;
      rs1_addr_d  = '0;
      rs2_addr_d  = '0;
      rd_addr_d   = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      pc_d        = '0;
    end else if (stall) begin
      // A writeback retiring while we hold must land in the held operand,
      // otherwise it is gone by the time the stall releases.
      if (wb_hit_rs1) rs1_data_d = wb_result;
      if (wb_hit_rs2) rs2_data_d = wb_result;
    end else begin
      valid_d     = id_valid;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
      branch_d    = id_branch;
      alu_src_d   = id_alu_src;
      sel_d       = id_alu_sel;
      rs1_addr_d  = id_rs1_addr;
      rs2_addr_d  = id_rs2_addr;
      rd_addr_d   = id_rd_addr;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      pc_d        = id_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      alu_src_q   <= 1'b0;
      sel_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      branch_q    <= branch_d;
      alu_src_q   <= alu_src_d;
      sel_q       <= sel_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (mem_hit_rs1)     fwd_rs1 = mem_result;
    else if (wb_hit_rs1) fwd_rs1 = wb_result;
    fwd_rs2 = rs2_data_q;
    if (mem_hit_rs2)     fwd_rs2 = mem_result;
    else if (wb_hit_rs2) fwd_rs2 = wb_result;
  end

  assign alu_op_a      = fwd_rs1;
  assign alu_op_b      = alu_src_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_sel       = sel_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_branch     = branch_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_pc         = pc_q;
  assign ex_imm        = imm_q;

  assign load_use_hazard = valid_q && mem_read_q && (rd_addr_q != '0) && id_valid &&
                           ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table for load/forward
// cases plus hand sequences for stall refresh, flush, reset and load-use.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        id_alu_src;
  logic [2:0]  id_alu_sel;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_result, wb_result;
  logic [31:0] alu_op_a, alu_op_b, ex_store_data, ex_pc, ex_imm;
  logic [2:0]  alu_sel;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [4:0]  ex_rd_addr;
  logic        load_use_hazard;

  int checks = 0;
  int failures = 0;

  id_ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .id_alu_src(id_alu_src), .id_alu_sel(id_alu_sel), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_sel(alu_sel),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_rd_addr(ex_rd_addr), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1a, rs2a, rd;
    logic [31:0] rs1d, rs2d, imm, pc;
    logic        src;
    logic [2:0]  sel;
    logic [3:0]  ctrl;   // {reg_write, mem_read, mem_write, branch}
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic [31:0] ea, eb, esd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd_off();
    mem_reg_write = 0; mem_rd_addr = 0; mem_result = 0;
    wb_reg_write = 0;  wb_rd_addr = 0;  wb_result = 0;
  endtask

  task automatic drive_id(input logic [4:0] rs1a, input logic [4:0] rs2a, input logic [4:0] rd,
                          input logic [31:0] rs1d, input logic [31:0] rs2d,
                          input logic [31:0] imm, input logic [31:0] pc,
                          input logic src, input logic [2:0] sel, input logic [3:0] ctrl);
    id_valid = 1; id_rs1_addr = rs1a; id_rs2_addr = rs2a; id_rd_addr = rd;
    id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm; id_pc = pc;
    id_alu_src = src; id_alu_sel = sel;
    {id_reg_write, id_mem_read, id_mem_write, id_branch} = ctrl;
  endtask

  initial begin
    //          rs1a rs2a rd  rs1d         rs2d         imm            pc           src sel   ctrl     mwe mrd mres        wwe wrd wres        ea           eb             esd
    vecs[0] = '{5'd1, 5'd2, 5'd3, 32'd5,       32'd7,       32'h0000_0000, 32'h100, 1'b0, 3'b001, 4'b1000, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  32'd5,  32'd7,         32'd7};
    vecs[1] = '{5'd3, 5'd5, 5'd6, 32'h11,      32'h22,      32'h0000_0004, 32'h104, 1'b0, 3'b000, 4'b1000, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hAA, 32'h22,        32'h22};
    vecs[2] = '{5'd3, 5'd5, 5'd6, 32'h11,      32'h22,      32'h0000_0004, 32'h108, 1'b0, 3'b000, 4'b1000, 1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hBB, 32'h22,        32'h22};
    vecs[3] = '{5'd0, 5'd0, 5'd1, 32'h33,      32'h44,      32'h0000_0000, 32'h10C, 1'b0, 3'b011, 4'b1000, 1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 32'h33, 32'h44,        32'h44};
    vecs[4] = '{5'd8, 5'd7, 5'd2, 32'd9,       32'd1,       32'hFFFF_FFF0, 32'h110, 1'b1, 3'b010, 4'b0010, 1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'h0,  32'd9,  32'hFFFF_FFF0, 32'h55};
    vecs[5] = '{5'd10, 5'd9, 5'd4, 32'd3,      32'd2,       32'h0000_0008, 32'h114, 1'b0, 3'b101, 4'b0101, 1'b1, 5'd10, 32'h66, 1'b1, 5'd9, 32'h77, 32'h66, 32'h77,       32'h77};
    vecs[6] = '{5'd4, 5'd4, 5'd5, 32'h12,      32'h13,      32'h0000_000C, 32'h118, 1'b0, 3'b011, 4'b0100, 1'b0, 5'd4, 32'h98, 1'b0, 5'd4, 32'h99, 32'h12, 32'h13,        32'h13};

    rst = 1; stall = 0; flush = 0;
    fwd_off();
    drive_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'hF, 32'h40, 1'b1, 3'b101, 4'b1111);
    tick();
    // reset with a live instruction on the decode inputs still clears everything
    chk("rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_op_a", alu_op_a, 32'd0);
    chk("rst_op_b", alu_op_b, 32'd0);
    chk("rst_store", ex_store_data, 32'd0);
    chk("rst_sel", {29'b0, alu_sel}, 32'd0);
    chk("rst_ctrl", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 32'd0);
    chk("rst_rd", {27'b0, ex_rd_addr}, 32'd0);
    chk("rst_pc_imm", ex_pc | ex_imm, 32'd0);
    chk("rst_hazard", {31'b0, load_use_hazard}, 32'd0);
    rst = 0;

    for (int i = 0; i < 7; i++) begin
      fwd_off();
      drive_id(vecs[i].rs1a, vecs[i].rs2a, vecs[i].rd, vecs[i].rs1d, vecs[i].rs2d,
               vecs[i].imm, vecs[i].pc, vecs[i].src, vecs[i].sel, vecs[i].ctrl);
      tick();
      mem_reg_write = vecs[i].mwe; mem_rd_addr = vecs[i].mrd; mem_result = vecs[i].mres;
      wb_reg_write  = vecs[i].wwe; wb_rd_addr  = vecs[i].wrd; wb_result  = vecs[i].wres;
      #1;
      chk($sformatf("v%0d_op_a", i), alu_op_a, vecs[i].ea);
      chk($sformatf("v%0d_op_b", i), alu_op_b, vecs[i].eb);
      chk($sformatf("v%0d_store", i), ex_store_data, vecs[i].esd);
      chk($sformatf("v%0d_sel", i), {29'b0, alu_sel}, {29'b0, vecs[i].sel});
      chk($sformatf("v%0d_valid", i), {31'b0, ex_valid}, 32'd1);
      chk($sformatf("v%0d_ctrl", i), {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch},
          {28'b0, vecs[i].ctrl});
      chk($sformatf("v%0d_rd", i), {27'b0, ex_rd_addr}, {27'b0, vecs[i].rd});
      chk($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
      chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].imm);
    end

    // Stall refresh: hold rs1=x2(0x10), rs2=x4(1) for three edges; wb writes x4=9 on the 2nd.
    fwd_off();
    drive_id(5'd2, 5'd4, 5'd7, 32'h10, 32'd1, 32'h20, 32'h200, 1'b0, 3'b001, 4'b1000);
    tick();
    stall = 1;
    drive_id(5'd9, 5'd9, 5'd9, 32'hDEAD, 32'hBEEF, 32'h1, 32'h300, 1'b1, 3'b111, 4'b0111);
    tick();
    chk("stall1_op_b", alu_op_b, 32'd1);
    chk("stall1_pc", ex_pc, 32'h200);
    wb_reg_write = 1; wb_rd_addr = 5'd4; wb_result = 32'd9;
    tick();
    fwd_off();
    tick();
    #1;
    chk("stall3_op_b", alu_op_b, 32'd9);
    chk("stall3_store", ex_store_data, 32'd9);
    chk("stall3_op_a", alu_op_a, 32'h10);
    chk("stall3_sel", {29'b0, alu_sel}, 32'd1);
    chk("stall3_rd", {27'b0, ex_rd_addr}, 32'd7);
    chk("stall3_imm", ex_imm, 32'h20);
    chk("stall3_ctrl", {27'b0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 32'b11000);

    // Flush beats stall.
    stall = 0;
    drive_id(5'd3, 5'd5, 5'd8, 32'h77, 32'h88, 32'h4, 32'h400, 1'b0, 3'b011, 4'b1111);
    tick();
    chk("preflush_ctrl", {27'b0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 32'b11111);
    stall = 1; flush = 1;
    tick();
    chk("flush_ctrl", {27'b0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 32'd0);
    chk("flush_sel", {29'b0, alu_sel}, 32'd0);
    chk("flush_rd", {27'b0, ex_rd_addr}, 32'd0);
    chk("flush_op_a", alu_op_a, 32'd0);
    stall = 0; flush = 0;

    // Reset during a stall empties the stage.
    drive_id(5'd3, 5'd5, 5'd8, 32'h77, 32'h88, 32'h4, 32'h400, 1'b0, 3'b011, 4'b1111);
    tick();
    stall = 1; rst = 1;
    tick();
    chk("rst_stall_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_stall_op_a", alu_op_a, 32'd0);
    stall = 0; rst = 0;

    // Load-use: EX holds a load to x6.
    drive_id(5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 32'h0, 32'h500, 1'b0, 3'b000, 4'b1100);
    tick();
    id_valid = 1; id_rs1_addr = 5'd1; id_rs2_addr = 5'd6; #1;
    chk("lu_rs2", {31'b0, load_use_hazard}, 32'd1);
    id_rs1_addr = 5'd6; id_rs2_addr = 5'd1; #1;
    chk("lu_rs1", {31'b0, load_use_hazard}, 32'd1);
    id_valid = 0; #1;
    chk("lu_idinvalid", {31'b0, load_use_hazard}, 32'd0);
    id_rs1_addr = 5'd2; id_rs2_addr = 5'd3; id_valid = 1; #1;
    chk("lu_nomatch", {31'b0, load_use_hazard}, 32'd0);
    // Load whose rd is x0 must not stall.
    drive_id(5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'h504, 1'b0, 3'b000, 4'b1100);
    tick();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; #1;
    chk("lu_x0", {31'b0, load_use_hazard}, 32'd0);
    // Non-load producer to x6 does not stall.
    drive_id(5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 32'h0, 32'h508, 1'b0, 3'b000, 4'b1000);
    tick();
    id_rs1_addr = 5'd6; #1;
    chk("lu_notload", {31'b0, load_use_hazard}, 32'd0);
    // Flushed (invalid) load does not stall.
    drive_id(5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 32'h0, 32'h50C, 1'b0, 3'b000, 4'b1100);
    id_valid = 0;
    tick();
    id_valid = 1; id_rs1_addr = 5'd6; #1;
    chk("lu_exinvalid", {31'b0, load_use_hazard}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
